arbitro_ventilador: RTL and testbench

ARBITRO_VENTILADOR -- requirements
Module: arbitro_ventilador

---
 rtl/ventilacion_pkg.sv | 21 ++
 rtl/arbitro_ventilador_selector_rr.sv | 45 ++++
 rtl/arbitro_ventilador.sv | 158 +++++++++++++++
 tb/tb_arbitro_ventilador.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/ventilacion_pkg.sv
// Shared definitions for the zone ventilation arbiter: state encoding,
// zone count, counter width and the round-robin pointer helper.
package ventilacion_pkg;

    localparam int N_ZONAS    = 4;
    localparam int ANCHO_ZONA = 2;
    localparam int ANCHO_CNT  = 8;

    typedef enum logic [1:0] {
        INACTIVO = 2'd0,
        ARRANQUE = 2'd1,
        SERVICIO = 2'd2,
        CAMBIO   = 2'd3
    } estado_t;

    // Pointer value after granting zone idx: one past the winner, wrapping 3->0.
    function automatic logic [ANCHO_ZONA-1:0] siguiente_ptr(input logic [ANCHO_ZONA-1:0] idx);
        return idx + ANCHO_ZONA'(1);
    endfunction

endpackage

// File: rtl/arbitro_ventilador_selector_rr.sv
// selector_rr: purely combinational round-robin priority selector.
// Alarm-class requests (request AND alarm) win over plain requests; inside the
// chosen class the search starts at ptr and moves upward, wrapping 3->0.
module selector_rr
    import ventilacion_pkg::*;
(
    input  logic [N_ZONAS-1:0]    solicitud,
    input  logic [N_ZONAS-1:0]    alarma,
    input  logic [ANCHO_ZONA-1:0] ptr,
    output logic                  valido,
    output logic [N_ZONAS-1:0]    ganador,
    output logic [ANCHO_ZONA-1:0] indice
);

    logic [N_ZONAS-1:0]    clase_alarma;
    logic [N_ZONAS-1:0]    mascara;
    logic [N_ZONAS-1:0]    rotada;
    logic [ANCHO_ZONA-1:0] desplaz;

    // Alarm class per zone, and the candidate vector rotated so bit 0 is zone ptr.
    generate
        for (genvar gi = 0; gi < N_ZONAS; gi++) begin : g_zona
            localparam logic [ANCHO_ZONA-1:0] OFS = ANCHO_ZONA'(gi);
            assign clase_alarma[gi] = solicitud[gi] & alarma[gi];
            assign rotada[gi]       = mascara[ptr + OFS];
        end
    endgenerate

    assign mascara = (|clase_alarma) ? clase_alarma : solicitud;

    // Lowest set bit of the rotated vector is the first candidate at or after ptr.
    always_comb begin
        desplaz = '0;
        for (int i = N_ZONAS - 1; i >= 0; i--) begin
            if (rotada[i]) begin
                desplaz = i[ANCHO_ZONA-1:0];
            end
        end
    end

    assign valido  = |mascara;
    assign indice  = ptr + desplaz;
    assign ganador = valido ? (N_ZONAS'(1) << indice) : '0;

endmodule

// File: rtl/arbitro_ventilador.sv
// arbitro_ventilador: shares one fan (and siren) among four zone FSMs.
// The fan spins up for T_ARRANQUE cycles before the first grant, each grant is
// held at least T_MIN cycles, and a one-cycle gap (CAMBIO) separates grants.
// Optional macro ARBITRO_PREEMPCION_EN lets an alarm-class request from a
// non-granted zone cut the minimum hold short.
module arbitro_ventilador
    import ventilacion_pkg::*;
#(
    parameter int T_ARRANQUE = 4,
    parameter int T_MIN      = 16
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic [N_ZONAS-1:0]    Solicitud,
    input  logic [N_ZONAS-1:0]    Alarma_in,
    output logic [N_ZONAS-1:0]    Concesion,
    output logic                  Ventilador,
    output logic                  Alarma,
    output logic [ANCHO_ZONA-1:0] Zona
);

    localparam logic [ANCHO_CNT-1:0] CARGA_ARRANQUE = ANCHO_CNT'(T_ARRANQUE - 1);
    localparam logic [ANCHO_CNT-1:0] CARGA_MIN      = ANCHO_CNT'(T_MIN - 1);

    estado_t               estado_reg, estado_next;
    logic [ANCHO_CNT-1:0]  cnt_reg, cnt_next;
    logic [ANCHO_ZONA-1:0] ptr_reg, ptr_next;
    logic [N_ZONAS-1:0]    concesion_reg, concesion_next;
    logic                  ventilador_reg, ventilador_next;
    logic                  alarma_reg, alarma_next;
    logic [ANCHO_ZONA-1:0] zona_reg, zona_next;

    logic                  otorgar;
    logic                  preempcion;
    logic                  sel_valido;
    logic [N_ZONAS-1:0]    sel_ganador;
    logic [ANCHO_ZONA-1:0] sel_indice;

    selector_rr u_selector (
        .solicitud (Solicitud),
        .alarma    (Alarma_in),
        .ptr       (ptr_reg),
        .valido    (sel_valido),
        .ganador   (sel_ganador),
        .indice    (sel_indice)
    );

`ifdef ARBITRO_PREEMPCION_EN
    // An alarm from a zone that is not currently served ends the hold at once.
    assign preempcion = |(Solicitud & Alarma_in & ~concesion_reg);
`else
    assign preempcion = 1'b0;
`endif

    // Next-state and next-output logic; outputs are all taken from registers.
    always_comb begin
        estado_next     = estado_reg;
        cnt_next        = cnt_reg;
        ptr_next        = ptr_reg;
        concesion_next  = concesion_reg;
        ventilador_next = ventilador_reg;
        zona_next       = zona_reg;
        otorgar         = 1'b0;

        case (estado_reg)
            INACTIVO: begin
                concesion_next = '0;
                if (|Solicitud) begin
                    estado_next     = ARRANQUE;
                    ventilador_next = 1'b1;
                    cnt_next        = CARGA_ARRANQUE;
                end else begin
                    ventilador_next = 1'b0;
                end
            end
            ARRANQUE: begin
                if (Solicitud == '0) begin
                    estado_next     = INACTIVO;
                    ventilador_next = 1'b0;
                end else if (cnt_reg == '0) begin
                    otorgar = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            SERVICIO: begin
                // Counter saturates at zero; the grant is held while it runs.
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - 1'b1;
                end
                if (preempcion) begin
                    estado_next    = CAMBIO;
                    concesion_next = '0;
                end else if (cnt_reg == '0) begin
                    if (Solicitud == '0) begin
                        estado_next     = INACTIVO;
                        concesion_next  = '0;
                        ventilador_next = 1'b0;
                    end else if (|(Solicitud & ~concesion_reg)) begin
                        estado_next    = CAMBIO;
                        concesion_next = '0;
                    end
                end
            end
            CAMBIO: begin
                concesion_next = '0;
                if (Solicitud == '0) begin
                    estado_next     = INACTIVO;
                    ventilador_next = 1'b0;
                end else begin
                    otorgar = 1'b1;
                end
            end
            default: begin
                estado_next = INACTIVO;
            end
        endcase

        if (otorgar && sel_valido) begin
            estado_next     = SERVICIO;
            concesion_next  = sel_ganador;
            ventilador_next = 1'b1;
            cnt_next        = CARGA_MIN;
            ptr_next        = siguiente_ptr(sel_indice);
            zona_next       = sel_indice;
        end
    end

    // Siren follows the alarm of whichever zone holds the fan, only while serving.
    assign alarma_next = (estado_next == SERVICIO) && (|(Alarma_in & concesion_next));

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            estado_reg     <= INACTIVO;
            cnt_reg        <= '0;
            ptr_reg        <= '0;
            concesion_reg  <= '0;
            ventilador_reg <= 1'b0;
            alarma_reg     <= 1'b0;
            zona_reg       <= '0;
        end else begin
            estado_reg     <= estado_next;
            cnt_reg        <= cnt_next;
            ptr_reg        <= ptr_next;
            concesion_reg  <= concesion_next;
            ventilador_reg <= ventilador_next;
            alarma_reg     <= alarma_next;
            zona_reg       <= zona_next;
        end
    end

    assign Concesion  = concesion_reg;
    assign Ventilador = ventilador_reg;
    assign Alarma     = alarma_reg;
    assign Zona       = zona_reg;

endmodule

// File: tb/tb_arbitro_ventilador.sv
// Directed testbench for arbitro_ventilador (default T_ARRANQUE=4, T_MIN=16).
// Each step drives inputs, queues the outputs expected after the next edge,
// then pops and compares them one cycle later. Expectations for the alarm
// scenario follow ARBITRO_PREEMPCION_EN when it is defined.
module tb_arbitro_ventilador;

    logic       CLK = 1'b0;
    logic       Reset;
    logic [3:0] Solicitud;
    logic [3:0] Alarma_in;
    logic [3:0] Concesion;
    logic       Ventilador;
    logic       Alarma;
    logic [1:0] Zona;

    typedef struct packed {
        logic [3:0] con;
        logic       ven;
        logic       ala;
        logic [1:0] zon;
    } salida_t;

    salida_t sb[$];
    int      vectores    = 0;
    int      miscompares = 0;

    arbitro_ventilador #(
        .T_ARRANQUE (4),
        .T_MIN      (16)
    ) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .Solicitud  (Solicitud),
        .Alarma_in  (Alarma_in),
        .Concesion  (Concesion),
        .Ventilador (Ventilador),
        .Alarma     (Alarma),
        .Zona       (Zona)
    );

    always #5 CLK = ~CLK;

    // One clock: drive inputs, queue expectation, compare after the edge.
    task automatic paso(input logic rst, input logic [3:0] sol, input logic [3:0] al,
                        input logic [3:0] econ, input logic even, input logic eala,
                        input logic [1:0] ezon, input string tag);
        salida_t esperado;
        salida_t observado;
        Reset     = rst;
        Solicitud = sol;
        Alarma_in = al;
        esperado  = {econ, even, eala, ezon};
        sb.push_back(esperado);
        @(posedge CLK);
        #1;
        esperado  = sb.pop_front();
        observado = {Concesion, Ventilador, Alarma, Zona};
        vectores++;
        assert (observado === esperado) else begin
            miscompares++;
            $error("FAIL %s: observed con=%b ven=%b ala=%b zona=%0d, expected con=%b ven=%b ala=%b zona=%0d",
                   tag, observado.con, observado.ven, observado.ala, observado.zon,
                   esperado.con, esperado.ven, esperado.ala, esperado.zon);
        end
    endtask

    task automatic paso_n(input int n, input logic rst, input logic [3:0] sol, input logic [3:0] al,
                          input logic [3:0] econ, input logic even, input logic eala,
                          input logic [1:0] ezon, input string tag);
        for (int k = 0; k < n; k++) begin
            paso(rst, sol, al, econ, even, eala, ezon, tag);
        end
    endtask

    initial begin
        Reset     = 1'b0;
        Solicitud = 4'b0000;
        Alarma_in = 4'b0000;

        // Reset state
        paso_n(2, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, "reset");

        // Spin-up latency: fan next cycle, grant 4 cycles later
        paso  (   1'b1, 4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, "arranque_vent");
        paso_n(3, 1'b1, 4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, "arranque_espera");
        paso  (   1'b1, 4'b0001, 4'b0000, 4'b0001, 1'b1, 1'b0, 2'd0, "primera_concesion");

        // Two requesters: grants alternate with a CAMBIO gap, 16 cycles each
        paso_n(15, 1'b1, 4'b0101, 4'b0000, 4'b0001, 1'b1, 1'b0, 2'd0, "hold_z0");
        paso  (    1'b1, 4'b0101, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, "cambio_1");
        paso  (    1'b1, 4'b0101, 4'b0000, 4'b0100, 1'b1, 1'b0, 2'd2, "concesion_z2");
        paso_n(15, 1'b1, 4'b0101, 4'b0000, 4'b0100, 1'b1, 1'b0, 2'd2, "hold_z2");
        paso  (    1'b1, 4'b0101, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd2, "cambio_2");
        paso  (    1'b1, 4'b0101, 4'b0000, 4'b0001, 1'b1, 1'b0, 2'd0, "concesion_z0_rr");

        // Granted zone drops after 3 cycles: hold continues to 16, then idle
        paso_n(2,  1'b1, 4'b0001, 4'b0000, 4'b0001, 1'b1, 1'b0, 2'd0, "hold_z0_activo");
        paso_n(13, 1'b1, 4'b0000, 4'b0000, 4'b0001, 1'b1, 1'b0, 2'd0, "hold_z0_caido");
        paso  (    1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, "fin_hold_inactivo");
        paso  (    1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, "inactivo");

        // Request vanishes during spin-up: back to idle, no grant
        paso  (   1'b1, 4'b0010, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, "arranque_z1");
        paso  (   1'b1, 4'b0010, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, "arranque_z1_b");
        paso  (   1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, "aborto_arranque");
        paso_n(5, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, "sin_concesion");

        // Zone 0 granted, zone 2 raises an alarm request mid-hold
        paso  (   1'b1, 4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, "arranque_z0");
        paso_n(3, 1'b1, 4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, "arranque_z0_espera");
        paso  (   1'b1, 4'b0001, 4'b0000, 4'b0001, 1'b1, 1'b0, 2'd0, "concesion_z0");
        paso_n(3, 1'b1, 4'b0001, 4'b0000, 4'b0001, 1'b1, 1'b0, 2'd0, "hold_pre_alarma");
`ifdef ARBITRO_PREEMPCION_EN
        paso  (    1'b1, 4'b0101, 4'b0100, 4'b0000, 1'b1, 1'b0, 2'd0, "preempcion_cambio");
`else
        paso_n(12, 1'b1, 4'b0101, 4'b0100, 4'b0001, 1'b1, 1'b0, 2'd0, "hold_sin_preempcion");
        paso  (    1'b1, 4'b0101, 4'b0100, 4'b0000, 1'b1, 1'b0, 2'd0, "cambio_expira");
`endif
        paso  (   1'b1, 4'b0101, 4'b0100, 4'b0100, 1'b1, 1'b1, 2'd2, "concesion_alarma");
        paso_n(2, 1'b1, 4'b0101, 4'b0100, 4'b0100, 1'b1, 1'b1, 2'd2, "hold_alarma");

        // Reset mid-SERVICIO clears everything; arbitration restarts at ptr=0
        paso  (   1'b0, 4'b0101, 4'b0100, 4'b0000, 1'b0, 1'b0, 2'd0, "reset_servicio");
        paso  (   1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, "tras_reset");
        paso  (   1'b1, 4'b1010, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, "arranque_1010");
        paso_n(3, 1'b1, 4'b1010, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, "arranque_1010_espera");
        paso  (   1'b1, 4'b1010, 4'b0000, 4'b0010, 1'b1, 1'b0, 2'd1, "rr_desde_ptr0");

        // Alarm class beats round-robin order at the next arbitration point
        paso_n(15, 1'b1, 4'b1010, 4'b0000, 4'b0010, 1'b1, 1'b0, 2'd1, "hold_z1");
        paso  (    1'b1, 4'b1010, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd1, "cambio_3");
        paso  (    1'b1, 4'b1010, 4'b0010, 4'b0010, 1'b1, 1'b1, 2'd1, "alarma_gana_rr");

        // Sole requester keeps the grant past the minimum hold
        paso_n(15, 1'b1, 4'b0010, 4'b0000, 4'b0010, 1'b1, 1'b0, 2'd1, "hold_z1_b");
        paso_n(4,  1'b1, 4'b0010, 4'b0000, 4'b0010, 1'b1, 1'b0, 2'd1, "persistencia");
        paso  (    1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd1, "fin_inactivo");

        $display("== %0d vectors applied, %0d miscompares ==", vectores, miscompares);
        $finish;
    end

endmodule
